gb_oam_dma: RTL and testbench

GB_OAM_DMA -- requirements
Module: gb_oam_dma

---
 rtl/gb_oam_dma.sv | 113 +++++++++++
 tb/tb_gb_oam_dma.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gb_oam_dma.sv
// OAM DMA engine: copies one XFER_LEN-byte image from a 256-byte source page into OAM.
// One read per cycle during XFER; each byte is written to OAM on the following cycle.
module gb_oam_dma #(
   parameter int XFER_LEN = 160
) (
   input  logic        clk_m,
   input  logic        reset,
   input  logic        dma_start,
   input  logic [15:0] dma_start_addr,
   output logic        mem_rd_en,
   output logic [15:0] mem_rd_addr,
   input  logic [7:0]  mem_rd_data,
   output logic        oam_wr_en,
   output logic [7:0]  oam_wr_addr,
   output logic [7:0]  oam_wr_data,
   output logic        dma_active,
   output logic        dma_done,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   state_t     state_q, state_d;
   logic [7:0] index_q, index_d;
   logic [7:0] page_q, page_d;
   logic       pend_q, pend_d;
   logic [7:0] pend_idx_q, pend_idx_d;
   logic       done_q, done_d;
   logic [7:0] start_page;

   // Pages 0xE0-0xFF are the echo of work RAM at 0xC0-0xDF.
   always_comb begin
      start_page = dma_start_addr[15:8];
      if (dma_start_addr[15:8] >= 8'hE0) begin
         start_page = dma_start_addr[15:8] - 8'h20;
      end
   end

   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      page_d     = page_q;
      pend_d     = 1'b0;
      pend_idx_d = pend_idx_q;
      done_d     = 1'b0;

      // A start request in any state (re)starts the copy; the read issued this
      // cycle is dropped because pend_d stays low.
      if (dma_start) begin
         state_d = SETUP;
         page_d  = start_page;
         index_d = 8'd0;
      end else begin
         case (state_q)
            SETUP: begin
               state_d = XFER;
               index_d = 8'd0;
            end
            XFER: begin
               pend_d     = 1'b1;
               pend_idx_d = index_q;
               if (index_q == LAST_IDX) begin
                  state_d = DRAIN;
               end else begin
                  index_d = index_q + 8'd1;
               end
            end
            DRAIN: begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_m) begin
      if (reset) begin
         state_q    <= IDLE;
         index_q    <= 8'd0;
         page_q     <= 8'd0;
         pend_q     <= 1'b0;
         pend_idx_q <= 8'd0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         page_q     <= page_d;
         pend_q     <= pend_d;
         pend_idx_q <= pend_idx_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      mem_rd_en   = (state_q == XFER);
      mem_rd_addr = mem_rd_en ? {page_q, index_q} : 16'h0000;
      oam_wr_en   = pend_q;
      oam_wr_addr = pend_q ? pend_idx_q : 8'h00;
      oam_wr_data = pend_q ? mem_rd_data : 8'h00;
      dma_active  = (state_q != IDLE);
      dma_done    = done_q;
      dbg_state   = state_q;
   end

endmodule

// File: tb/tb_gb_oam_dma.sv
// Bench for gb_oam_dma: per-window stimulus tables replayed cycle by cycle against an
// event-level model (transfer start edges, cutoffs, per-offset reads/writes/done).
module tb_gb_oam_dma;

   localparam int XFER_LEN = 160;
   localparam int N        = 600;

   logic        clk_m = 1'b0;
   logic        reset = 1'b1;
   logic        dma_start = 1'b0;
   logic [15:0] dma_start_addr = 16'h0000;
   logic        mem_rd_en;
   logic [15:0] mem_rd_addr;
   logic [7:0]  mem_rd_data = 8'h00;
   logic        oam_wr_en;
   logic [7:0]  oam_wr_addr;
   logic [7:0]  oam_wr_data;
   logic        dma_active;
   logic        dma_done;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [65536];
   bit          st [N];
   bit          rs [N];
   logic [15:0] ad [N];
   logic [35:0] exp_v [N];

   gb_oam_dma #(.XFER_LEN(XFER_LEN)) dut (
      .clk_m          (clk_m),
      .reset          (reset),
      .dma_start      (dma_start),
      .dma_start_addr (dma_start_addr),
      .mem_rd_en      (mem_rd_en),
      .mem_rd_addr    (mem_rd_addr),
      .mem_rd_data    (mem_rd_data),
      .oam_wr_en      (oam_wr_en),
      .oam_wr_addr    (oam_wr_addr),
      .oam_wr_data    (oam_wr_data),
      .dma_active     (dma_active),
      .dma_done       (dma_done),
      .dbg_state      (dbg_state)
   );

   // ---------------- clock / source memory ----------------
   always #5 clk_m = ~clk_m;

   // Synchronous source memory; junk on idle cycles so leakage shows up.
   always @(posedge clk_m) begin
      mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 8'($urandom);
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] remap(input logic [7:0] p);
      return (p >= 8'hE0) ? p - 8'h20 : p;
   endfunction

   // Packing: {active, done, rd_en, rd_addr[15:0], wr_en, wr_addr[7:0], wr_data[7:0]}
   // A transfer starting at edge e: SETUP cycle e, reads cycles e+1..e+160,
   // writes e+2..e+161, done e+162. Everything from cutoff onward is lost.
   task automatic fill(input int e, input logic [7:0] page, input int cut);
      for (int c = e; c < cut && c < e + XFER_LEN + 3 && c < N; c++) begin
         int d;
         logic [35:0] v;
         d = c - e;
         v = '0;
         if (d <= XFER_LEN + 1) v[35] = 1'b1;
         if (d == XFER_LEN + 2) v[34] = 1'b1;
         if (d >= 1 && d <= XFER_LEN) begin
            v[33]    = 1'b1;
            v[32:17] = {page, 8'(d - 1)};
         end
         if (d >= 2 && d <= XFER_LEN + 1) begin
            v[16]   = 1'b1;
            v[15:8] = 8'(d - 2);
            v[7:0]  = mem[{page, 8'(d - 2)}];
         end
         exp_v[c] = v;
      end
   endtask

   task automatic build_model();
      int         e_cur;
      logic [7:0] p_cur;
      e_cur = -1;
      p_cur = 8'h00;
      for (int c = 0; c < N; c++) exp_v[c] = '0;
      for (int k = 1; k < N; k++) begin
         if (rs[k-1]) begin
            if (e_cur >= 0) fill(e_cur, p_cur, k);
            e_cur = -1;
         end else if (st[k-1]) begin
            if (e_cur >= 0) fill(e_cur, p_cur, k);
            e_cur = k;
            p_cur = remap(ad[k-1][15:8]);
         end
      end
      if (e_cur >= 0) fill(e_cur, p_cur, N);
   endtask

   // ---------------- driver ----------------
   task automatic clear_stim();
      for (int c = 0; c < N; c++) begin
         st[c] = 1'b0;
         rs[c] = 1'b0;
         ad[c] = 16'($urandom);
      end
   endtask

   // Entered at a negedge with the DUT idle; cycle c follows edge c.
   task automatic run_window(input string name);
      logic [35:0] obs;
      build_model();
      for (int c = 0; c < N; c++) begin
         obs = {dma_active, dma_done, mem_rd_en, mem_rd_addr,
                oam_wr_en, oam_wr_addr, oam_wr_data};
         checks++;
         if (obs !== exp_v[c]) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs, exp_v[c]);
         end
         dma_start      = st[c];
         reset          = rs[c];
         dma_start_addr = ad[c];
         @(posedge clk_m);
         @(negedge clk_m);
      end
      dma_start = 1'b0;
      reset     = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset     = 1'b1;
      dma_start = 1'b1;
      dma_start_addr = 16'hC100;
      @(posedge clk_m);
      @(posedge clk_m);
      @(negedge clk_m);
      checks++; if (dma_active  !== 1'b0)  begin errors++; $display("FAIL reset_active got %b want 0", dma_active); end
      checks++; if (dma_done    !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", dma_done); end
      checks++; if (mem_rd_en   !== 1'b0)  begin errors++; $display("FAIL reset_rd_en got %b want 0", mem_rd_en); end
      checks++; if (mem_rd_addr !== 16'h0) begin errors++; $display("FAIL reset_rd_addr got %h want 0", mem_rd_addr); end
      checks++; if (oam_wr_en   !== 1'b0)  begin errors++; $display("FAIL reset_wr_en got %b want 0", oam_wr_en); end
      checks++; if (oam_wr_addr !== 8'h0)  begin errors++; $display("FAIL reset_wr_addr got %h want 0", oam_wr_addr); end
      checks++; if (oam_wr_data !== 8'h0)  begin errors++; $display("FAIL reset_wr_data got %h want 0", oam_wr_data); end
      reset     = 1'b0;
      dma_start = 1'b0;
      @(posedge clk_m);
      @(negedge clk_m);
   endtask

   task automatic test_basic();
      clear_stim();
      st[0] = 1'b1; ad[0] = 16'hC100;
      run_window("basic");
   endtask

   task automatic test_remap();
      clear_stim();
      st[0] = 1'b1;   ad[0] = 16'hE345;
      st[170] = 1'b1; ad[170] = {8'($urandom_range(224, 255)), 8'($urandom)};
      st[340] = 1'b1; ad[340] = {8'($urandom_range(0, 223)), 8'($urandom)};
      run_window("remap");
   endtask

   task automatic test_restart();
      clear_stim();
      st[0] = 1'b1;  ad[0] = 16'hC100;
      st[52] = 1'b1; ad[52] = 16'hD000;
      st[220] = 1'b1;
      st[220 + $urandom_range(2, 160)] = 1'b1;
      run_window("restart");
   endtask

   task automatic test_reset_mid();
      clear_stim();
      st[0] = 1'b1;
      rs[82] = 1'b1; st[82] = 1'b1;
      st[90] = 1'b1; ad[90] = 16'hC100;
      st[300] = 1'b1;
      rs[462] = 1'b1;
      run_window("reset_mid");
   endtask

   task automatic test_back_to_back();
      clear_stim();
      st[0] = 1'b1;
      st[163] = 1'b1;
      st[340] = 1'b1; st[341] = 1'b1; st[342] = 1'b1;
      run_window("back_to_back");
   endtask

   task automatic test_random();
      for (int it = 0; it < 3; it++) begin
         clear_stim();
         for (int c = 0; c < N - 170; c++) begin
            if ($urandom_range(0, 59) == 0) st[c] = 1'b1;
            if ($urandom_range(0, 199) == 0) rs[c] = 1'b1;
         end
         run_window("random");
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      @(negedge clk_m);
      test_reset();
      test_basic();
      test_remap();
      test_restart();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
